// File: rtl/div_issue_ctrl.sv
// EX-stage issue controller for the multi-cycle divider: launches DIV/DIVU, stalls the
// front end for the whole division, aborts on flush and writes quotient/remainder to LO/HI.
module div_issue_ctrl #(
  parameter logic [5:0] DIV_OP    = 6'b011010,
  parameter logic [5:0] DIVU_OP   = 6'b011011,
  parameter int         ABORT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic [5:0]  ex_op_i,
  input  logic [31:0] ex_rs_i,
  input  logic [31:0] ex_rt_i,
  input  logic        flush_i,
  input  logic        pipe_stall_i,
  output logic        stall_o,
  output logic [5:0]  div_op_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  output logic        div_start_o,
  output logic        div_annul_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [1:0]  dbg_state_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_ABORT = 2'd3;

  localparam int ACW = (ABORT_CYC > 1) ? $clog2(ABORT_CYC) : 1;

  logic [1:0]     state_q, state_d;
  logic [ACW-1:0] abort_cnt_q, abort_cnt_d;
  logic [5:0]     op_q;
  logic [31:0]    op1_q, op2_q;
  logic [31:0]    hi_q, lo_q;
  logic           is_div;
  logic           issue;
  logic           capture;

  assign is_div = ex_valid_i & ((ex_op_i == DIV_OP) | (ex_op_i == DIVU_OP));

  // Divider handshake: div_start_o is held high for the whole division and the divider
  // answers with a single div_ready_i cycle while start is still high; the result is
  // taken in that cycle. div_annul_o is a one-cycle kill with start already low.
  always_comb begin
    state_d     = state_q;
    abort_cnt_d = abort_cnt_q;
    issue       = 1'b0;
    capture     = 1'b0;
    stall_o     = 1'b0;
    div_start_o = 1'b0;
    div_annul_o = 1'b0;
    hilo_we_o   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_div && !flush_i) begin
          issue   = 1'b1;
          stall_o = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        stall_o = 1'b1;
        if (flush_i) begin
          div_annul_o = 1'b1;
          abort_cnt_d = '0;
          state_d     = S_ABORT;
        end else begin
          div_start_o = 1'b1;
          if (div_ready_i) begin
            capture = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        // A flushed instruction must not update HI/LO, even if the result is ready.
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (!pipe_stall_i) begin
          hilo_we_o = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_ABORT: begin
        stall_o = is_div;
        if (abort_cnt_q == ACW'(ABORT_CYC - 1)) begin
          state_d = S_IDLE;
        end else begin
          abort_cnt_d = abort_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      abort_cnt_q <= '0;
      op_q        <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      abort_cnt_q <= abort_cnt_d;
      if (issue) begin
        op_q  <= ex_op_i;
        op1_q <= ex_rs_i;
        op2_q <= ex_rt_i;
      end
      if (capture) begin
        hi_q <= div_result_i[63:32];
        lo_q <= div_result_i[31:0];
      end
    end
  end

  assign div_op_o    = op_q;
  assign div_op1_o   = op1_q;
  assign div_op2_o   = op2_q;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: behavioural divider (34-cycle normal, 2-cycle by-zero latency),
// directed divides with hand-computed HI/LO pushed to a queue and checked on each write pulse.
module tb_div_issue_ctrl;

  localparam logic [5:0] DIV_OP  = 6'b011010;
  localparam logic [5:0] DIVU_OP = 6'b011011;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i;
  logic [5:0]  ex_op_i;
  logic [31:0] ex_rs_i, ex_rt_i;
  logic        flush_i, pipe_stall_i;
  logic        stall_o;
  logic [5:0]  div_op_o;
  logic [31:0] div_op1_o, div_op2_o;
  logic        div_start_o, div_annul_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        hilo_we_o;
  logic [31:0] hi_o, lo_o;
  logic [1:0]  dbg_state_o;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q[$];

  div_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .ex_op_i(ex_op_i), .ex_rs_i(ex_rs_i), .ex_rt_i(ex_rt_i),
    .flush_i(flush_i), .pipe_stall_i(pipe_stall_i), .stall_o(stall_o),
    .div_op_o(div_op_o), .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
    .div_start_o(div_start_o), .div_annul_o(div_annul_o),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i),
    .hilo_we_o(hilo_we_o), .hi_o(hi_o), .lo_o(lo_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- divider model ----------------
  logic [5:0] mcnt;
  always @(posedge clk) begin
    if (rst || !div_start_o) mcnt <= '0;
    else                     mcnt <= mcnt + 6'd1;
  end

  assign div_ready_i = div_start_o && (mcnt == ((div_op2_o == 32'd0) ? 6'd1 : 6'd33));

  always_comb begin
    div_result_i = '0;
    if (div_op2_o != 32'd0) begin
      if (div_op_o == DIV_OP) begin
        div_result_i[31:0]  = $signed(div_op1_o) / $signed(div_op2_o);
        div_result_i[63:32] = $signed(div_op1_o) % $signed(div_op2_o);
      end else begin
        div_result_i[31:0]  = div_op1_o / div_op2_o;
        div_result_i[63:32] = div_op1_o % div_op2_o;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected HI/LO pair.
  always @(negedge clk) begin
    if (!rst && hilo_we_o) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got hi=%h lo=%h expected no write", hi_o, lo_o);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({hi_o, lo_o} !== e) begin
          fails++;
          $display("FAIL hilo_write: got hi=%h lo=%h expected hi=%h lo=%h",
                   hi_o, lo_o, e[63:32], e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_div(input string name, input logic [5:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] ehi, input logic [31:0] elo,
                         input int estall, input int npstall);
    int sc;
    exp_q.push_back({ehi, elo});
    ex_valid_i = 1'b1; ex_op_i = op; ex_rs_i = rs; ex_rt_i = rt;
    pipe_stall_i = (npstall > 0);
    sc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall_o) break;
      sc++;
      @(posedge clk); #1;
      // Retired from EX; scramble operands to prove the latched copies are used.
      ex_valid_i = 1'b0; ex_rs_i = $urandom; ex_rt_i = $urandom;
    end
    chk({name, "_stall_cycles"}, 64'(sc), 64'(estall));
    for (int i = 1; i < npstall; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk({name, "_held_state"}, 64'(dbg_state_o), 64'(2));
      chk({name, "_held_stall"}, 64'(stall_o), 64'(0));
      chk({name, "_held_nowrite"}, 64'(hilo_we_o), 64'(0));
    end
    @(posedge clk); #1;
    if (npstall > 0) begin
      pipe_stall_i = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; ex_valid_i = 1'b0; ex_op_i = '0; ex_rs_i = '0; ex_rt_i = '0;
    flush_i = 1'b0; pipe_stall_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_state", 64'(dbg_state_o), 64'(0));
    chk("rst_stall", 64'(stall_o), 64'(0));
    chk("rst_start", 64'(div_start_o), 64'(0));
    chk("rst_annul", 64'(div_annul_o), 64'(0));
    chk("rst_we", 64'(hilo_we_o), 64'(0));
    chk("rst_hilo", {hi_o, lo_o}, 64'(0));
    chk("rst_ops", {div_op1_o, div_op2_o}, 64'(0));
    @(posedge clk); #1;

    run_div("divu_100_7", DIVU_OP, 32'd100, 32'd7, 32'd2, 32'd14, 35, 0);
    run_div("div_m7_2", DIV_OP, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 35, 0);
    run_div("div_7_m2", DIV_OP, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 35, 0);
    run_div("div_by_zero", DIV_OP, 32'd5, 32'd0, 32'd0, 32'd0, 3, 0);

    // Divide presented together with a flush in IDLE is ignored.
    ex_valid_i = 1'b1; ex_op_i = DIV_OP; ex_rs_i = 32'd8; ex_rt_i = 32'd2; flush_i = 1'b1;
    @(negedge clk);
    chk("idle_flush_stall", 64'(stall_o), 64'(0));
    @(posedge clk); #1;
    ex_valid_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    chk("idle_flush_state", 64'(dbg_state_o), 64'(0));
    @(posedge clk); #1;

    // Flush on BUSY cycle 10, then a new DIVU waits out the abort window.
    ex_valid_i = 1'b1; ex_op_i = DIVU_OP; ex_rs_i = 32'd1000; ex_rt_i = 32'd3;
    @(posedge clk); #1;
    ex_valid_i = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_annul", 64'(div_annul_o), 64'(1));
    chk("flush_start", 64'(div_start_o), 64'(0));
    @(posedge clk); #1;
    flush_i = 1'b0;
    ex_valid_i = 1'b1; ex_op_i = DIVU_OP; ex_rs_i = 32'd9; ex_rt_i = 32'd3;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("abort_state", 64'(dbg_state_o), 64'(3));
      chk("abort_stall", 64'(stall_o), 64'(1));
      chk("abort_annul", {63'd0, div_annul_o | div_start_o}, 64'(0));
      @(posedge clk); #1;
    end
    run_div("divu_9_3", DIVU_OP, 32'd9, 32'd3, 32'd0, 32'd3, 35, 0);

    run_div("pstall_50_8", DIVU_OP, 32'd50, 32'd8, 32'd2, 32'd6, 35, 4);
    run_div("b2b_20_6", DIVU_OP, 32'd20, 32'd6, 32'd2, 32'd3, 35, 0);
    run_div("b2b_5_5", DIVU_OP, 32'd5, 32'd5, 32'd0, 32'd1, 35, 0);

    // Flush while the result waits in DONE: no write.
    ex_valid_i = 1'b1; ex_op_i = DIVU_OP; ex_rs_i = 32'd10; ex_rt_i = 32'd3; pipe_stall_i = 1'b1;
    @(posedge clk); #1;
    ex_valid_i = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall_o) break;
      @(posedge clk); #1;
    end
    chk("done_flush_state", 64'(dbg_state_o), 64'(2));
    @(posedge clk); #1;
    flush_i = 1'b1;
    @(negedge clk);
    chk("done_flush_nowrite", 64'(hilo_we_o), 64'(0));
    @(posedge clk); #1;
    flush_i = 1'b0; pipe_stall_i = 1'b0;
    @(negedge clk);
    chk("done_flush_idle", 64'(dbg_state_o), 64'(0));
    @(posedge clk); #1;

    // Reset in BUSY: back to IDLE, registers cleared, no write afterwards.
    ex_valid_i = 1'b1; ex_op_i = DIVU_OP; ex_rs_i = 32'd20; ex_rt_i = 32'd6;
    @(posedge clk); #1;
    ex_valid_i = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("busy_rst_state", 64'(dbg_state_o), 64'(0));
    chk("busy_rst_stall", 64'(stall_o), 64'(0));
    chk("busy_rst_start", 64'(div_start_o), 64'(0));
    chk("busy_rst_hilo", {hi_o, lo_o}, 64'(0));
    repeat (40) @(posedge clk);
    #1;

    chk("exp_queue_empty", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
